// File: rtl/mem_arbiter.sv
// Arbiter sharing one unified memory between the fetch port and the LSU port, one transaction in flight.
// Optional fetch starvation guard is enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_gnt_o,
  output logic              i_rvalid_o,
  output logic [31:0]       i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [7:0]        d_be_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [7:0]        m_be_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic              m_gnt_i,
  input  logic              m_rvalid_i,
  input  logic [DATA_W-1:0] m_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  state_t state_q;
  logic   addr2_q;
  logic   idle;
  logic   sel_d;
  logic   sel_i;
  logic   force_i;
  logic   i_hs;
  logic   d_hs;

  // Qualifying with rst_n keeps every output at 0 while reset is held, even with requests present.
  assign idle  = rst_n && (state_q == IDLE);
  assign sel_d = idle && d_req_i && !force_i;
  assign sel_i = idle && i_req_i && !sel_d;
  assign d_hs  = sel_d && m_gnt_i;
  assign i_hs  = sel_i && m_gnt_i;

  always_comb begin
    // NOTE: every output is given a default first so no path through this block infers a latch.
    m_req_o   = 1'b0;
    m_we_o    = 1'b0;
    m_be_o    = 8'h00;
    m_addr_o  = '0;
    m_wdata_o = '0;
    if (sel_d) begin
      m_req_o   = 1'b1;
      m_we_o    = d_we_i;
      m_be_o    = d_be_i;
      m_addr_o  = d_addr_i;
      m_wdata_o = d_wdata_i;
    end else if (sel_i) begin
      m_req_o  = 1'b1;
      m_be_o   = 8'hFF;
      m_addr_o = i_addr_i;
    end
  end

  assign i_gnt_o = i_hs;
  assign d_gnt_o = d_hs;

  // Responses are routed in the same cycle; a response arriving in IDLE belongs to nobody.
  assign i_rvalid_o = rst_n && (state_q == WAIT_I) && m_rvalid_i;
  assign d_rvalid_o = rst_n && (state_q == WAIT_D) && m_rvalid_i;
  assign i_rdata_o  = !i_rvalid_o ? 32'h0 :
                      addr2_q     ? m_rdata_i[63:32] : m_rdata_i[31:0];
  assign d_rdata_o  = d_rvalid_o ? m_rdata_i : '0;
  assign busy_o     = (state_q != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr2_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (d_hs) begin
            state_q <= WAIT_D;
          end else if (i_hs) begin
            state_q <= WAIT_I;
            addr2_q <= i_addr_i[2];
          end
        end
        WAIT_I: if (m_rvalid_i) state_q <= IDLE;
        WAIT_D: if (m_rvalid_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int LIM_W = $clog2(STARVE_LIMIT + 1);
  localparam int CNT_W = (LIM_W > 3) ? LIM_W : 3;

  logic [CNT_W-1:0] starve_q;

  // Counts data grants taken while fetch was waiting; reaching the limit hands the next slot to fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (!i_req_i || i_hs) begin
      starve_q <= '0;
    end else if (d_hs) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  assign force_i = i_req_i && (starve_q == CNT_W'(STARVE_LIMIT));
`else
  // Never true for a legal limit: strict data priority.
  assign force_i = (STARVE_LIMIT < 0);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, hand-written corner sequences, rdata scoreboard.
// A behavioural memory answers handshakes after a programmable latency.
module tb_mem_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              i_req_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic              i_gnt_o;
  logic              i_rvalid_o;
  logic [31:0]       i_rdata_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [7:0]        d_be_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [DATA_W-1:0] d_rdata_o;
  logic              m_req_o;
  logic              m_we_o;
  logic [7:0]        m_be_o;
  logic [ADDR_W-1:0] m_addr_o;
  logic [DATA_W-1:0] m_wdata_o;
  logic              m_gnt_i;
  logic              m_rvalid_i;
  logic [DATA_W-1:0] m_rdata_i;
  logic              busy_o;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_be_o(m_be_o), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural memory ----------------
  logic [63:0] mem [logic [60:0]];
  logic [63:0] rsp_word;
  int          hs_seq = 0;
  int          rsp_taken = 0;
  int          rsp_cnt = 0;
  int          rsp_lat = 1;
  int          inj_seq = 0;
  int          inj_done = 0;

  function automatic logic [63:0] init_word(input logic [60:0] k);
    case (k)
      61'h200: return 64'hAAAA_BBBB_CCCC_DDDD;
      61'h400: return 64'h0123_4567_89AB_CDEF;
      default: return 64'hDEAD_BEEF_0BAD_F00D;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst_n && m_req_o && m_gnt_i) begin
      logic [60:0] k;
      logic [63:0] w;
      k = m_addr_o[63:3];
      w = mem.exists(k) ? mem[k] : init_word(k);
      if (m_we_o) begin
        for (int b = 0; b < 8; b++)
          if (m_be_o[b]) w[8*b +: 8] = m_wdata_o[8*b +: 8];
        mem[k]   = w;
        rsp_word = 64'h0;
      end else begin
        rsp_word = w;
      end
      hs_seq++;
    end
  end

  always @(negedge clk) begin
    m_rvalid_i = 1'b0;
    m_rdata_i  = '0;
    if (!rst_n) begin
      rsp_taken = hs_seq;
      rsp_cnt   = 0;
    end else if (inj_seq != inj_done) begin
      inj_done   = inj_seq;
      m_rvalid_i = 1'b1;
      m_rdata_i  = 64'hFEED_FACE_CAFE_BABE;
    end else begin
      if (rsp_taken != hs_seq) begin
        rsp_taken = hs_seq;
        rsp_cnt   = rsp_lat;
      end
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          m_rvalid_i = 1'b1;
          m_rdata_i  = rsp_word;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int          n_vec = 0;
  int          n_bad = 0;
  int          pops = 0;
  logic [63:0] exp_i_q [$];
  logic [63:0] exp_d_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [63:0] e;
    if (i_rvalid_o) begin
      if (exp_i_q.size() == 0) check("i_rvalid_unexpected", 64'(i_rvalid_o), 64'h0);
      else begin
        e = exp_i_q.pop_front();
        check("i_rdata", 64'(i_rdata_o), e);
        pops++;
      end
    end else check("i_rdata_zero_when_idle", 64'(i_rdata_o), 64'h0);
    if (d_rvalid_o) begin
      if (exp_d_q.size() == 0) check("d_rvalid_unexpected", 64'(d_rvalid_o), 64'h0);
      else begin
        e = exp_d_q.pop_front();
        check("d_rdata", d_rdata_o, e);
        pops++;
      end
    end else check("d_rdata_zero_when_idle", d_rdata_o, 64'h0);
  endtask

  // Advance to just after the next falling edge, after the memory model has driven its response.
  task automatic cycle();
    @(negedge clk);
    #2;
    monitor();
  endtask

  task automatic wait_rsp(input int target);
    int k = 0;
    while (pops < target && k < 30) begin
      cycle();
      k++;
    end
    check("rsp_arrived", 64'(pops), 64'(target));
  endtask

  typedef struct {
    logic        is_fetch;
    logic        we;
    logic [7:0]  be;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          lat;
    logic        exp_we;
    logic [7:0]  exp_be;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic do_txn(input vec_t v);
    int target;
    cycle();
    rsp_lat = v.lat;
    if (v.is_fetch) begin
      i_req_i = 1'b1; i_addr_i = v.addr;
    end else begin
      d_req_i = 1'b1; d_we_i = v.we; d_be_i = v.be; d_addr_i = v.addr; d_wdata_i = v.wdata;
    end
    #1;
    check("m_req", 64'(m_req_o), 64'h1);
    check("m_we", 64'(m_we_o), 64'(v.exp_we));
    check("m_be", 64'(m_be_o), 64'(v.exp_be));
    check("m_addr", m_addr_o, v.addr);
    if (!v.is_fetch) check("m_wdata", m_wdata_o, v.wdata);
    check("i_gnt", 64'(i_gnt_o), 64'(v.is_fetch));
    check("d_gnt", 64'(d_gnt_o), 64'(!v.is_fetch));
    if (v.is_fetch) exp_i_q.push_back(v.exp_rdata);
    else            exp_d_q.push_back(v.exp_rdata);
    target = pops + 1;
    cycle();
    i_req_i = 1'b0;
    d_req_i = 1'b0;
    #1;
    check("busy_in_wait", 64'(busy_o), 64'h1);
    check("m_req_in_wait", 64'(m_req_o), 64'h0);
    check("gnt_in_wait", 64'({i_gnt_o, d_gnt_o}), 64'h0);
    wait_rsp(target);
    cycle();
    #1;
    check("busy_after_rsp", 64'(busy_o), 64'h0);
  endtask

  initial begin
    int target;
    int cnt_m;
    logic exp_fetch;

    vecs[0]  = '{1'b1, 1'b0, 8'h00, 64'h1004, 64'h0, 2, 1'b0, 8'hFF, 64'h0000_0000_AAAA_BBBB};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 64'h1000, 64'h0, 1, 1'b0, 8'hFF, 64'h0000_0000_CCCC_DDDD};
    vecs[2]  = '{1'b0, 1'b0, 8'hFF, 64'h2000, 64'h0, 3, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF};
    vecs[3]  = '{1'b0, 1'b1, 8'h0F, 64'h2000, 64'h11, 1, 1'b1, 8'h0F, 64'h0};
    vecs[4]  = '{1'b0, 1'b0, 8'hFF, 64'h2000, 64'h0, 2, 1'b0, 8'hFF, 64'h0123_4567_0000_0011};
    vecs[5]  = '{1'b0, 1'b1, 8'hF0, 64'h2008, 64'hFFEE_DDCC_BBAA_9988, 2, 1'b1, 8'hF0, 64'h0};
    vecs[6]  = '{1'b0, 1'b0, 8'hFF, 64'h2008, 64'h0, 1, 1'b0, 8'hFF, 64'hFFEE_DDCC_0BAD_F00D};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 64'h200C, 64'h0, 2, 1'b0, 8'hFF, 64'h0000_0000_FFEE_DDCC};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 64'h2008, 64'h0, 3, 1'b0, 8'hFF, 64'h0000_0000_0BAD_F00D};
    vecs[9]  = '{1'b0, 1'b1, 8'hFF, 64'h3000, 64'h5555_6666_7777_8888, 1, 1'b1, 8'hFF, 64'h0};
    vecs[10] = '{1'b0, 1'b0, 8'hFF, 64'h3000, 64'h0, 2, 1'b0, 8'hFF, 64'h5555_6666_7777_8888};

    // Reset with both requests asserted: every output must stay low.
    rst_n = 1'b0;
    i_req_i = 1'b1; i_addr_i = 64'h1004;
    d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 8'hFF; d_addr_i = 64'h2000; d_wdata_i = 64'h1;
    m_gnt_i = 1'b1;
    #12;
    check("rst_m_req", 64'(m_req_o), 64'h0);
    check("rst_m_we_be", 64'({m_we_o, m_be_o}), 64'h0);
    check("rst_gnt", 64'({i_gnt_o, d_gnt_o}), 64'h0);
    check("rst_rvalid", 64'({i_rvalid_o, d_rvalid_o}), 64'h0);
    check("rst_busy", 64'(busy_o), 64'h0);
    i_req_i = 1'b0;
    d_req_i = 1'b0;
    d_we_i  = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    #1;
    check("post_rst_busy", 64'(busy_o), 64'h0);
    check("post_rst_m_req", 64'(m_req_o), 64'h0);

    for (int i = 0; i < 11; i++) do_txn(vecs[i]);

    // Contention: data wins, fetch only after data response plus one IDLE cycle.
    cycle();
    rsp_lat = 2;
    i_req_i = 1'b1; i_addr_i = 64'h1004;
    d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 8'hFF; d_addr_i = 64'h2008;
    #1;
    check("cont_d_gnt", 64'(d_gnt_o), 64'h1);
    check("cont_i_gnt", 64'(i_gnt_o), 64'h0);
    check("cont_addr", m_addr_o, 64'h2008);
    exp_d_q.push_back(64'hFFEE_DDCC_0BAD_F00D);
    target = pops + 1;
    cycle();
    d_req_i = 1'b0;
    for (int k = 0; k < 30 && pops < target; k++) begin
      #1;
      check("cont_i_gnt_held", 64'(i_gnt_o), 64'h0);
      cycle();
    end
    #1;
    check("cont_i_gnt_held", 64'(i_gnt_o), 64'h0);
    check("cont_d_done", 64'(pops), 64'(target));
    cycle();
    #1;
    check("cont_i_gnt_late", 64'(i_gnt_o), 64'h1);
    check("cont_i_addr", m_addr_o, 64'h1004);
    exp_i_q.push_back(64'hAAAA_BBBB);
    target = pops + 1;
    cycle();
    i_req_i = 1'b0;
    wait_rsp(target);
    cycle();

    // Memory stalls the grant: request stays presented and stable, FSM stays idle.
    m_gnt_i = 1'b0;
    d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 8'hFF; d_addr_i = 64'h3000;
    rsp_lat = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_m_req", 64'(m_req_o), 64'h1);
      check("stall_m_addr", m_addr_o, 64'h3000);
      check("stall_gnt", 64'({i_gnt_o, d_gnt_o}), 64'h0);
      check("stall_busy", 64'(busy_o), 64'h0);
      cycle();
    end
    m_gnt_i = 1'b1;
    #1;
    check("stall_release_gnt", 64'(d_gnt_o), 64'h1);
    exp_d_q.push_back(64'h5555_6666_7777_8888);
    target = pops + 1;
    cycle();
    d_req_i = 1'b0;
    wait_rsp(target);
    cycle();

    // Reset in WAIT_D; a response just after release must be dropped.
    cycle();
    rsp_lat = 20;
    d_req_i = 1'b1; d_addr_i = 64'h2000;
    #1;
    check("rstw_d_gnt", 64'(d_gnt_o), 64'h1);
    cycle();
    #1;
    check("rstw_busy", 64'(busy_o), 64'h1);
    rst_n = 1'b0;
    #1;
    check("rstw_busy_cleared", 64'(busy_o), 64'h0);
    check("rstw_m_req", 64'(m_req_o), 64'h0);
    check("rstw_d_gnt_low", 64'(d_gnt_o), 64'h0);
    cycle();
    cycle();
    d_req_i = 1'b0;
    rst_n = 1'b1;
    cycle();
    inj_seq++;
    cycle();
    #1;
    check("late_rsp_dropped", 64'({i_rvalid_o, d_rvalid_o}), 64'h0);
    check("late_rsp_rdata", d_rdata_o, 64'h0);
    check("late_rsp_busy", 64'(busy_o), 64'h0);
    cycle();

    // Both ports held: strict data priority, or D,D,D,D,I with the guard.
    rsp_lat = 1;
    cnt_m = 0;
    i_req_i = 1'b1; i_addr_i = 64'h1004;
    d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 8'hFF; d_addr_i = 64'h1000;
    for (int r = 0; r < 10; r++) begin
      #1;
      exp_fetch = GUARD && (cnt_m == 4);
      check("guard_i_gnt", 64'(i_gnt_o), 64'(exp_fetch));
      check("guard_d_gnt", 64'(d_gnt_o), 64'(!exp_fetch));
      if (exp_fetch) begin
        exp_i_q.push_back(64'hAAAA_BBBB);
        cnt_m = 0;
      end else begin
        exp_d_q.push_back(64'hAAAA_BBBB_CCCC_DDDD);
        cnt_m++;
      end
      target = pops + 1;
      wait_rsp(target);
      cycle();
    end
    i_req_i = 1'b0;
    d_req_i = 1'b0;
    cycle();
    cycle();

    check("sb_i_leftover", 64'(exp_i_q.size()), 64'h0);
    check("sb_d_leftover", 64'(exp_d_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
